// File: rtl/plab5_mcore_dma_arb_pkg.sv
// plab5_mcore_dma_arb_pkg: shared state encodings and security-domain constants for the DMA request arbiter.
package plab5_mcore_dma_arb_pkg;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCRUB = 3'd1,
      ST_ISSUE = 3'd2,
      ST_BUSY  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;
   localparam logic DOM_L = 1'b0;
   localparam logic DOM_H = 1'b1;
endpackage

// File: rtl/plab5_mcore_rr_picker.sv
// plab5_mcore_rr_picker: combinational round-robin picker, first valid at or above rr_ptr with wrap.
module plab5_mcore_rr_picker
   import plab5_mcore_dma_arb_pkg::*;
#(
   parameter int p_num_reqs = 4,
   localparam int c_ptr_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
) (
   input  logic [p_num_reqs-1:0]  req_val,
   input  logic [c_ptr_nbits-1:0] rr_ptr,
   output logic [p_num_reqs-1:0]  grant,
   output logic [c_ptr_nbits-1:0] grant_idx,
   output logic                   any_val
);
   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      grant_idx = '0;
      for (int k = p_num_reqs - 1; k >= 0; k--)
         if (req_val[(int'(rr_ptr) + k) % p_num_reqs])
            grant_idx = c_ptr_nbits'((int'(rr_ptr) + k) % p_num_reqs);
   end
   assign any_val = |req_val;
   assign grant   = any_val ? (p_num_reqs'(1) << grant_idx) : '0;
endmodule

// File: rtl/plab5_mcore_dma_req_arbiter.sv
// plab5_mcore_dma_req_arbiter: round-robin sharing of one DMA controller with domain-change scrub bubbles.
// Optional watchdog abort enabled by defining PLAB5_MCORE_DMA_ARB_TIMEOUT_EN.
module plab5_mcore_dma_req_arbiter
   import plab5_mcore_dma_arb_pkg::*;
#(
   parameter int p_num_reqs       = 4,
   parameter int p_addr_nbits     = 32,
   parameter int p_timeout_cycles = 256
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [p_num_reqs-1:0]             req_val,
   output logic [p_num_reqs-1:0]             req_rdy,
   input  logic [p_num_reqs-1:0]             req_domain,
   input  logic [p_num_reqs*p_addr_nbits-1:0] req_src_addr,
   input  logic [p_num_reqs*p_addr_nbits-1:0] req_dest_addr,
   output logic [p_num_reqs-1:0]             req_ack,
   output logic                              req_err,
   output logic                              dma_val,
   input  logic                              dma_rdy,
   output logic                              dma_domain,
   output logic [p_addr_nbits-1:0]           dma_src_addr,
   output logic [p_addr_nbits-1:0]           dma_dest_addr,
   input  logic                              dma_ack
);
   localparam int c_ptr_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
   state_t                   state;
   logic [c_ptr_nbits-1:0]   rr_ptr, grant_idx, pick_idx;
   logic [p_num_reqs-1:0]    pick_grant;
   logic                     any_val, last_domain, lat_domain, timed_out, timeout_hit;
   logic [p_addr_nbits-1:0]  lat_src, lat_dest;
   plab5_mcore_rr_picker #(.p_num_reqs(p_num_reqs)) picker (
      .req_val   (req_val),
      .rr_ptr    (rr_ptr),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any_val   (any_val)
   );
`ifdef PLAB5_MCORE_DMA_ARB_TIMEOUT_EN
   localparam int c_cnt_nbits = $clog2(p_timeout_cycles + 1);
   logic [c_cnt_nbits-1:0] tcnt;
   // Held at zero outside ISSUE/BUSY, so it reads 0 on the first ISSUE cycle.
   always_ff @(posedge clk)
      if (reset || !(state == ST_ISSUE || state == ST_BUSY)) tcnt <= '0;
      else if (!timeout_hit) tcnt <= tcnt + 1'b1;
   assign timeout_hit = (tcnt == c_cnt_nbits'(p_timeout_cycles));
`else
   assign timeout_hit = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         last_domain <= DOM_L;
         grant_idx   <= '0;
         lat_src     <= '0;
         lat_dest    <= '0;
         lat_domain  <= DOM_L;
         timed_out   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (any_val) begin
               grant_idx  <= pick_idx;
               lat_src    <= req_src_addr[pick_idx*p_addr_nbits +: p_addr_nbits];
               lat_dest   <= req_dest_addr[pick_idx*p_addr_nbits +: p_addr_nbits];
               lat_domain <= req_domain[pick_idx];
               timed_out  <= 1'b0;
               state      <= (req_domain[pick_idx] != last_domain) ? ST_SCRUB : ST_ISSUE;
            end
            ST_SCRUB: begin
               last_domain <= lat_domain;
               state       <= ST_ISSUE;
            end
            ST_ISSUE: if (timeout_hit) begin
               timed_out <= 1'b1;
               state     <= ST_RESP;
            end else if (dma_rdy) state <= ST_BUSY;
            ST_BUSY: if (timeout_hit) begin
               timed_out <= 1'b1;
               state     <= ST_RESP;
            end else if (dma_ack) state <= ST_RESP;
            ST_RESP: begin
               rr_ptr <= (grant_idx == c_ptr_nbits'(p_num_reqs - 1)) ? '0 : grant_idx + 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
   // Latched fields are only exposed once the scrub bubble has passed.
   logic held;
   assign held          = (state == ST_ISSUE) || (state == ST_BUSY) || (state == ST_RESP);
   assign req_rdy       = (state == ST_IDLE) ? pick_grant : '0;
   assign req_ack       = (state == ST_RESP) ? (p_num_reqs'(1) << grant_idx) : '0;
   assign req_err       = (state == ST_RESP) && timed_out;
   assign dma_val       = (state == ST_ISSUE);
   assign dma_domain    = held && lat_domain;
   assign dma_src_addr  = held ? lat_src : '0;
   assign dma_dest_addr = held ? lat_dest : '0;
endmodule
